aes_inv_core: RTL

//  Iterative AES-128 decryption core (FIPS-197 inverse cipher), one round per clock.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_inv_sbox_lut.sv | 28 ++
 rtl/aes_sbox_lut.sv | 28 ++
 rtl/aes_inv_core.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the inverse cipher datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column word holds row 0 in the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
            gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
            gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
            gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox_lut.sv
// Inverse AES S-box, combinational 256-entry lookup (InvSubBytes, one byte per instance).
module aes_inv_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign d = INV_SBOX[a];

endmodule

// File: rtl/aes_sbox_lut.sv
// Forward AES S-box, combinational 256-entry lookup (used by the key schedule SubWord).
module aes_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign d = SBOX[a];

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher: key schedule into an 11-entry round-key store,
// then one decryption round per clock. Byte 0 of every 128-bit word sits in bits [127:120].
module aes_inv_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         done,
  output logic [127:0] text_out
);

  logic [3:0]   kcnt_q, kcnt_d;
  logic [3:0]   dcnt_q, dcnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] w_q, w_d;
  logic         key_ready_q, key_ready_d;
  logic [127:0] rk_q [11];

  // ---------------- key expansion ----------------
  logic [31:0]  rot_word, sub_word, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] w_next;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;

  assign rot_word = {w_q[23:0], w_q[31:24]};
  assign rcon_idx = 4'd10 - kcnt_q;
  assign rcon     = (kcnt_q != 4'd0) ? RCON[rcon_idx] : 8'h00;

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox_lut u_sbox (
      .a(rot_word[8*i +: 8]),
      .d(sub_word[8*i +: 8])
    );
  end

  assign temp   = sub_word ^ {rcon, 24'h000000};
  assign n0     = w_q[127:96] ^ temp;
  assign n1     = w_q[95:64]  ^ n0;
  assign n2     = w_q[63:32]  ^ n1;
  assign n3     = w_q[31:0]   ^ n2;
  assign w_next = {n0, n1, n2, n3};

  // ---------------- round datapath ----------------
  logic         ld_accept;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd;
  logic [127:0] isr, isb, ark, imc, round_out;

  assign ld_accept = ld && key_ready_q && (kcnt_q == 4'd0) && !kld;
  // rk[10] feeds the initial AddRoundKey; otherwise the round counter picks the key.
  assign rk_rd_idx = (ld_accept || dcnt_q == 4'd0) ? 4'(AES_NR) : dcnt_q - 4'd1;
  assign rk_rd     = rk_q[rk_rd_idx];

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int B = r + 4 * c;
      localparam int S = r + 4 * ((c - r + 4) % 4);
      assign isr[127-8*B -: 8] = state_q[127-8*S -: 8];
      aes_inv_sbox_lut u_inv_sbox (
        .a(isr[127-8*B -: 8]),
        .d(isb[127-8*B -: 8])
      );
    end
  end

  assign ark = isb ^ rk_rd;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign round_out = (dcnt_q == 4'd1) ? ark : imc;

  // ---------------- next state ----------------
  always_comb begin
    kcnt_d      = kcnt_q;
    w_d         = w_q;
    key_ready_d = key_ready_q;
    dcnt_d      = dcnt_q;
    state_d     = state_q;

    if (kld) begin
      w_d         = key;
      kcnt_d      = 4'(AES_NR);
      key_ready_d = 1'b0;
    end else if (kcnt_q != 4'd0) begin
      w_d    = w_next;
      kcnt_d = kcnt_q - 4'd1;
      if (kcnt_q == 4'd1) key_ready_d = 1'b1;
    end

    // A new key invalidates any block in flight.
    if (kld) begin
      if (dcnt_q != 4'd0) begin
        dcnt_d  = 4'd0;
        state_d = '0;
      end
    end else if (ld_accept) begin
      state_d = text_in ^ rk_rd;
      dcnt_d  = 4'(AES_NR);
    end else if (dcnt_q != 4'd0) begin
      state_d = round_out;
      dcnt_d  = dcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt_q      <= 4'd0;
      dcnt_q      <= 4'd0;
      state_q     <= '0;
      w_q         <= '0;
      key_ready_q <= 1'b0;
    end else begin
      kcnt_q      <= kcnt_d;
      dcnt_q      <= dcnt_d;
      state_q     <= state_d;
      w_q         <= w_d;
      key_ready_q <= key_ready_d;
    end
  end

  // Round-key store: single write port, no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (kld) begin
        rk_q[0] <= key;
      end else if (kcnt_q != 4'd0) begin
        rk_q[4'd11 - kcnt_q] <= w_next;
      end
    end
  end

  assign key_ready = key_ready_q;
  assign done      = (dcnt_q == 4'd0);
  assign text_out  = state_q;

endmodule
